// File: rtl/topp.sv
// APB-slave UART: CSR/STATUS/TXDATA/RXDATA registers, TX and RX byte FIFOs, serializer,
// deserializer and level interrupt. Define UART_LOOPBACK_EN to enable internal loopback (CSR[7]).
module topp #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] CSR_RESET  = 32'h0000_0000
) (
  input  logic        pclk,
  input  logic        prst,
  input  logic        p_sel,
  input  logic        p_en,
  input  logic        p_wr,
  input  logic [31:0] p_addr,
  input  logic [31:0] pw_data,
  output logic        p_ready,
  output logic [31:0] pr_data,
  output logic        pslverr,
  output logic        tx,
  input  logic        rx,
  output logic        interupt_out
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
`ifdef UART_LOOPBACK_EN
  localparam logic [31:0] CsrMask = 32'h0003_FFFF;
`else
  localparam logic [31:0] CsrMask = 32'h0003_FF7F;
`endif

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic [31:0] csr_q, csr_d;
  logic        perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic        irq_q, irq_d;

  logic [PtrW:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [PtrW:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic          tx_empty, tx_full, rx_empty, rx_full;

  logic        xfer, wr_csr, wr_tx, rd_stat, rd_rx, err;
  logic [31:0] rdata;
  logic [7:0]  status;
  logic        loop_en;
  logic [3:0]  nbits_csr;

  // TX state
  state_e     tx_state_q, tx_state_d;
  logic [7:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d, tx_shift_q, tx_shift_d;
  logic [3:0] tx_nbits_q, tx_nbits_d, tx_bit_q, tx_bit_d;
  logic       tx_par_q, tx_par_d, tx_par_en_q, tx_par_en_d, tx_two_q, tx_two_d;
  logic       tx_stop2_q, tx_stop2_d, tx_q, tx_d;
  logic       tx_pop, tx_start, tx_tick;
  logic [7:0] tx_head, tx_mask;

  // RX state
  state_e     rx_state_q, rx_state_d;
  logic [7:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_shift_q, rx_shift_d;
  logic [3:0] rx_nbits_q, rx_nbits_d, rx_bit_q, rx_bit_d;
  logic       rx_par_en_q, rx_par_en_d, rx_odd_q, rx_odd_d, rx_acc_q, rx_acc_d;
  logic       rx_meta_q, rx_sync_q, rx_prev_q, rx_in, rx_fall, rx_tick;
  logic       rx_done, rx_push, set_perr, set_ferr;
  logic [8:0] rx_half;
  logic [7:0] rx_byte;

  assign p_ready = 1'b1;
  assign xfer    = p_sel & p_en;

  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[PtrW] != tx_rptr_q[PtrW]) &&
                    (tx_wptr_q[PtrW-1:0] == tx_rptr_q[PtrW-1:0]);
  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[PtrW] != rx_rptr_q[PtrW]) &&
                    (rx_wptr_q[PtrW-1:0] == rx_rptr_q[PtrW-1:0]);

  assign status = {(tx_state_q != StIdle), ovr_q, ferr_q, perr_q,
                   rx_full, rx_empty, tx_full, tx_empty};

`ifdef UART_LOOPBACK_EN
  assign loop_en = csr_q[7];
`else
  assign loop_en = 1'b0;
`endif

  assign nbits_csr = (csr_q[3:0] < 4'd5) ? 4'd5 :
                     (csr_q[3:0] > 4'd8) ? 4'd8 : csr_q[3:0];

  // APB decode; rejected accesses have no side effect.
  always_comb begin
    err     = 1'b0;
    rdata   = 32'h0;
    wr_csr  = 1'b0;
    wr_tx   = 1'b0;
    rd_stat = 1'b0;
    rd_rx   = 1'b0;
    if (xfer) begin
      if (p_addr > 32'd3) begin
        err = 1'b1;
      end else begin
        case (p_addr[1:0])
          2'd0: begin
            if (p_wr) wr_csr = 1'b1;
            else      rdata  = csr_q;
          end
          2'd1: begin
            if (p_wr) begin
              err = 1'b1;
            end else begin
              rd_stat = 1'b1;
              rdata   = {24'h0, status};
            end
          end
          2'd2: begin
            if (!p_wr || tx_full) err   = 1'b1;
            else                  wr_tx = 1'b1;
          end
          default: begin
            if (p_wr || rx_empty) begin
              err = 1'b1;
            end else begin
              rd_rx = 1'b1;
              rdata = {24'h0, rx_mem_q[rx_rptr_q[PtrW-1:0]]};
            end
          end
        endcase
      end
    end
  end

  assign pr_data = rdata;
  assign pslverr = err;

  // TX serializer
  assign tx_head = tx_mem_q[tx_rptr_q[PtrW-1:0]];
  assign tx_mask = 8'hFF >> (4'd8 - nbits_csr);
  assign tx_tick = (tx_cnt_q == tx_div_q);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_shift_d = tx_shift_q;
    tx_nbits_d = tx_nbits_q;
    tx_bit_d   = tx_bit_q;
    tx_par_d   = tx_par_q;
    tx_par_en_d = tx_par_en_q;
    tx_two_d   = tx_two_q;
    tx_stop2_d = tx_stop2_q;
    tx_d       = tx_q;
    tx_start   = 1'b0;
    tx_pop     = 1'b0;
    if (tx_state_q != StIdle) tx_cnt_d = tx_tick ? 8'd0 : tx_cnt_q + 8'd1;
    case (tx_state_q)
      StIdle: begin
        tx_cnt_d = 8'd0;
        tx_d     = 1'b1;
        if (!tx_empty) tx_start = 1'b1;
      end
      StStart: begin
        if (tx_tick) begin
          tx_state_d = StData;
          tx_d       = tx_shift_q[0];
          tx_bit_d   = 4'd0;
        end
      end
      StData: begin
        if (tx_tick) begin
          if (tx_bit_q == tx_nbits_q - 4'd1) begin
            tx_stop2_d = 1'b0;
            if (tx_par_en_q) begin
              tx_state_d = StParity;
              tx_d       = tx_par_q;
            end else begin
              tx_state_d = StStop;
              tx_d       = 1'b1;
            end
          end else begin
            tx_shift_d = tx_shift_q >> 1;
            tx_d       = tx_shift_q[1];
            tx_bit_d   = tx_bit_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (tx_tick) begin
          tx_state_d = StStop;
          tx_d       = 1'b1;
        end
      end
      StStop: begin
        if (tx_tick) begin
          if (tx_two_q && !tx_stop2_q) begin
            tx_stop2_d = 1'b1;
          end else if (!tx_empty) begin
            tx_start = 1'b1;
          end else begin
            tx_state_d = StIdle;
            tx_d       = 1'b1;
          end
        end
      end
      default: tx_state_d = StIdle;
    endcase
    // Frame format is captured here so later CSR writes only affect the next frame.
    if (tx_start) begin
      tx_pop      = 1'b1;
      tx_state_d  = StStart;
      tx_cnt_d    = 8'd0;
      tx_d        = 1'b0;
      tx_shift_d  = tx_head;
      tx_div_d    = csr_q[15:8];
      tx_nbits_d  = nbits_csr;
      tx_par_en_d = csr_q[4];
      tx_par_d    = (^(tx_head & tx_mask)) ^ csr_q[5];
      tx_two_d    = csr_q[6];
    end
  end

  assign tx = loop_en ? 1'b1 : tx_q;

  // RX deserializer
  assign rx_in   = loop_en ? tx_q : rx_sync_q;
  assign rx_fall = rx_prev_q & ~rx_in;
  assign rx_tick = (rx_cnt_q == rx_div_q);
  assign rx_half = ({1'b0, rx_div_q} + 9'd1) >> 1;
  assign rx_byte = rx_shift_q >> (4'd8 - rx_nbits_q);

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_div_d    = rx_div_q;
    rx_shift_d  = rx_shift_q;
    rx_nbits_d  = rx_nbits_q;
    rx_bit_d    = rx_bit_q;
    rx_par_en_d = rx_par_en_q;
    rx_odd_d    = rx_odd_q;
    rx_acc_d    = rx_acc_q;
    rx_done     = 1'b0;
    set_perr    = 1'b0;
    set_ferr    = 1'b0;
    case (rx_state_q)
      StIdle: begin
        if (rx_fall) begin
          rx_state_d  = StStart;
          rx_cnt_d    = 8'd0;
          rx_div_d    = csr_q[15:8];
          rx_nbits_d  = nbits_csr;
          rx_par_en_d = csr_q[4];
          rx_odd_d    = csr_q[5];
        end
      end
      StStart: begin
        if ({1'b0, rx_cnt_q} == rx_half) begin
          rx_cnt_d = 8'd0;
          rx_bit_d = 4'd0;
          rx_acc_d = 1'b0;
          rx_state_d = rx_in ? StIdle : StData;
        end else begin
          rx_cnt_d = rx_cnt_q + 8'd1;
        end
      end
      StData: begin
        rx_cnt_d = rx_tick ? 8'd0 : rx_cnt_q + 8'd1;
        if (rx_tick) begin
          rx_shift_d = {rx_in, rx_shift_q[7:1]};
          rx_acc_d   = rx_acc_q ^ rx_in;
          if (rx_bit_q == rx_nbits_q - 4'd1) rx_state_d = rx_par_en_q ? StParity : StStop;
          else                               rx_bit_d   = rx_bit_q + 4'd1;
        end
      end
      StParity: begin
        rx_cnt_d = rx_tick ? 8'd0 : rx_cnt_q + 8'd1;
        if (rx_tick) begin
          set_perr   = (rx_in != (rx_acc_q ^ rx_odd_q));
          rx_state_d = StStop;
        end
      end
      StStop: begin
        rx_cnt_d = rx_tick ? 8'd0 : rx_cnt_q + 8'd1;
        if (rx_tick) begin
          set_ferr   = ~rx_in;
          rx_done    = 1'b1;
          rx_state_d = StIdle;
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  assign rx_push = rx_done & ~rx_full;

  // Pointers, CSR, sticky flags, interrupt
  always_comb begin
    tx_wptr_d = wr_tx   ? tx_wptr_q + 1'b1 : tx_wptr_q;
    tx_rptr_d = tx_pop  ? tx_rptr_q + 1'b1 : tx_rptr_q;
    rx_wptr_d = rx_push ? rx_wptr_q + 1'b1 : rx_wptr_q;
    rx_rptr_d = rd_rx   ? rx_rptr_q + 1'b1 : rx_rptr_q;
    csr_d     = wr_csr  ? (pw_data & CsrMask) : csr_q;
    perr_d    = (perr_q & ~rd_stat) | set_perr;
    ferr_d    = (ferr_q & ~rd_stat) | set_ferr;
    ovr_d     = (ovr_q & ~rd_stat) | (rx_done & rx_full);
    irq_d     = (csr_q[16] & ~rx_empty) | (csr_q[17] & (perr_q | ferr_q | ovr_q));
  end

  always_ff @(posedge pclk) begin
    if (wr_tx)   tx_mem_q[tx_wptr_q[PtrW-1:0]] <= pw_data[7:0];
    if (rx_push) rx_mem_q[rx_wptr_q[PtrW-1:0]] <= rx_byte;
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      csr_q       <= CSR_RESET & CsrMask;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      irq_q       <= 1'b0;
      tx_wptr_q   <= '0;
      tx_rptr_q   <= '0;
      rx_wptr_q   <= '0;
      rx_rptr_q   <= '0;
      tx_state_q  <= StIdle;
      tx_cnt_q    <= 8'd0;
      tx_div_q    <= 8'd0;
      tx_shift_q  <= 8'd0;
      tx_nbits_q  <= 4'd5;
      tx_bit_q    <= 4'd0;
      tx_par_q    <= 1'b0;
      tx_par_en_q <= 1'b0;
      tx_two_q    <= 1'b0;
      tx_stop2_q  <= 1'b0;
      tx_q        <= 1'b1;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= StIdle;
      rx_cnt_q    <= 8'd0;
      rx_div_q    <= 8'd0;
      rx_shift_q  <= 8'd0;
      rx_nbits_q  <= 4'd5;
      rx_bit_q    <= 4'd0;
      rx_par_en_q <= 1'b0;
      rx_odd_q    <= 1'b0;
      rx_acc_q    <= 1'b0;
    end else begin
      csr_q       <= csr_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
      irq_q       <= irq_d;
      tx_wptr_q   <= tx_wptr_d;
      tx_rptr_q   <= tx_rptr_d;
      rx_wptr_q   <= rx_wptr_d;
      rx_rptr_q   <= rx_rptr_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_div_q    <= tx_div_d;
      tx_shift_q  <= tx_shift_d;
      tx_nbits_q  <= tx_nbits_d;
      tx_bit_q    <= tx_bit_d;
      tx_par_q    <= tx_par_d;
      tx_par_en_q <= tx_par_en_d;
      tx_two_q    <= tx_two_d;
      tx_stop2_q  <= tx_stop2_d;
      tx_q        <= tx_d;
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_in;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_div_q    <= rx_div_d;
      rx_shift_q  <= rx_shift_d;
      rx_nbits_q  <= rx_nbits_d;
      rx_bit_q    <= rx_bit_d;
      rx_par_en_q <= rx_par_en_d;
      rx_odd_q    <= rx_odd_d;
      rx_acc_q    <= rx_acc_d;
    end
  end

  assign interupt_out = irq_q;

endmodule

// File: tb/tb_topp.sv
// Directed self-checking bench for the topp APB UART.
module tb_topp;

  localparam int unsigned Depth = 8;

  logic        pclk, prst, p_sel, p_en, p_wr;
  logic [31:0] p_addr, pw_data, pr_data;
  logic        p_ready, pslverr, tx, rx, interupt_out;
  logic        rx_drv, loop_sel;

  int n_checks = 0;
  int n_errors = 0;

  assign rx = loop_sel ? tx : rx_drv;

  topp #(.FIFO_DEPTH(Depth), .CSR_RESET(32'h0000_0000)) dut (
    .pclk(pclk), .prst(prst), .p_sel(p_sel), .p_en(p_en), .p_wr(p_wr), .p_addr(p_addr),
    .pw_data(pw_data), .p_ready(p_ready), .pr_data(pr_data), .pslverr(pslverr), .tx(tx),
    .rx(rx), .interupt_out(interupt_out)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output logic err);
    @(posedge pclk); #1;
    p_sel = 1'b1; p_en = 1'b0; p_wr = 1'b1; p_addr = addr; pw_data = data;
    @(posedge pclk); #1;
    p_en = 1'b1; #1;
    err = pslverr;
    @(posedge pclk); #1;
    p_sel = 1'b0; p_en = 1'b0; p_wr = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
    @(posedge pclk); #1;
    p_sel = 1'b1; p_en = 1'b0; p_wr = 1'b0; p_addr = addr;
    @(posedge pclk); #1;
    p_en = 1'b1; #1;
    data = pr_data;
    err  = pslverr;
    @(posedge pclk); #1;
    p_sel = 1'b0; p_en = 1'b0;
  endtask

  // Drives one 8-data-bit frame at 8 pclk per bit.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    logic [10:0] bits;
    bits = {stop, par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge pclk);
      rx_drv = bits[i];
      repeat (7) @(negedge pclk);
    end
    @(negedge pclk);
    rx_drv = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        e;
    logic [31:0] d;
    logic [11:0] tx_bits;
    int          k;

    prst = 1'b1; p_sel = 1'b0; p_en = 1'b0; p_wr = 1'b0; p_addr = '0; pw_data = '0;
    rx_drv = 1'b1; loop_sel = 1'b0;
    repeat (3) @(posedge pclk);
    @(negedge pclk) prst = 1'b0;

    // Reset state
    check_eq("rst_tx", {31'h0, tx}, 32'h1);
    check_eq("rst_irq", {31'h0, interupt_out}, 32'h0);
    check_eq("rst_ready", {31'h0, p_ready}, 32'h1);
    apb_read(32'd1, d, e);
    check_eq("rst_status", d, 32'h5);
    apb_read(32'd0, d, e);
    check_eq("rst_csr", d, 32'h0);
    check_eq("rst_csr_err", {31'h0, e}, 32'h0);

    // TX waveform: 8 data, odd parity, 2 stop, DIV=7
    apb_write(32'd0, 32'h0000_0778, e);
    apb_read(32'd0, d, e);
    check_eq("csr_rb", d, 32'h0000_0778);
    apb_write(32'd2, 32'h3a3a_3a3a, e);
    check_eq("txdata_err", {31'h0, e}, 32'h0);
    for (k = 0; k < 20 && tx !== 1'b0; k++) @(negedge pclk);
    check_eq("tx_start_seen", {31'h0, tx}, 32'h0);
    tx_bits = {2'b11, 1'b1, 8'h3a, 1'b0};
    for (int b = 0; b < 12; b++) begin
      repeat (4) @(negedge pclk);
      check_eq($sformatf("tx_bit%0d", b), {31'h0, tx}, {31'h0, tx_bits[b]});
      repeat (4) @(negedge pclk);
    end
    check_eq("tx_idle_after", {31'h0, tx}, 32'h1);
    repeat (4) @(negedge pclk);
    apb_read(32'd1, d, e);
    check_eq("status_after_tx", d, 32'h5);

    // Loop rx to tx
    loop_sel = 1'b1;
    apb_write(32'd2, 32'h0000_003a, e);
    apb_write(32'd2, 32'h0000_00f6, e);
    repeat (1400) @(posedge pclk);
    apb_read(32'd1, d, e);
    check_eq("loop_status", d, 32'h1);
    apb_read(32'd3, d, e);
    check_eq("loop_rx0", d, 32'h3a);
    check_eq("loop_rx0_err", {31'h0, e}, 32'h0);
    apb_read(32'd3, d, e);
    check_eq("loop_rx1", d, 32'hf6);
    apb_read(32'd3, d, e);
    check_eq("rx_empty_err", {31'h0, e}, 32'h1);
    check_eq("rx_empty_data", d, 32'h0);
    loop_sel = 1'b0;

    // Error frames with error interrupt enabled
    apb_write(32'd0, 32'h0002_0778, e);
    send_frame(8'h3a, 1'b0, 1'b1);
    repeat (16) @(negedge pclk);
    check_eq("irq_perr", {31'h0, interupt_out}, 32'h1);
    send_frame(8'h55, 1'b1, 1'b0);
    repeat (16) @(negedge pclk);
    check_eq("irq_still", {31'h0, interupt_out}, 32'h1);
    apb_read(32'd1, d, e);
    check_eq("err_status", d, 32'h31);
    apb_read(32'd1, d, e);
    check_eq("err_cleared", d, 32'h1);
    repeat (3) @(negedge pclk);
    check_eq("irq_cleared", {31'h0, interupt_out}, 32'h0);
    apb_read(32'd3, d, e);
    check_eq("perr_byte", d, 32'h3a);
    apb_read(32'd3, d, e);
    check_eq("ferr_byte", d, 32'h55);

    // Back-to-back TXDATA burst with slow baud
    apb_write(32'd0, 32'h0000_ff08, e);
    @(posedge pclk); #1;
    p_sel = 1'b1; p_en = 1'b0; p_wr = 1'b1; p_addr = 32'd2;
    @(posedge pclk); #1;
    p_en = 1'b1;
    for (int i = 0; i < Depth + 2; i++) begin
      pw_data = 32'h40 + i;
      #1;
      check_eq($sformatf("burst%0d_err", i), {31'h0, pslverr},
               (i == Depth + 1) ? 32'h1 : 32'h0);
      @(posedge pclk); #1;
    end
    p_sel = 1'b0; p_en = 1'b0; p_wr = 1'b0;
    apb_read(32'd1, d, e);
    check_eq("full_status", d, 32'h86);

    // Illegal accesses
    apb_write(32'd1, 32'h0, e);
    check_eq("wr_status_err", {31'h0, e}, 32'h1);
    apb_write(32'd3, 32'h0, e);
    check_eq("wr_rxdata_err", {31'h0, e}, 32'h1);
    apb_write(32'd5, 32'h0, e);
    check_eq("wr_addr5_err", {31'h0, e}, 32'h1);
    apb_read(32'd2, d, e);
    check_eq("rd_txdata_err", {31'h0, e}, 32'h1);
    apb_read(32'd0, d, e);
    check_eq("csr_untouched", d, 32'h0000_ff08);

    // Reset mid-frame
    @(negedge pclk);
    check_eq("tx_mid_frame", {31'h0, tx}, 32'h0);
    prst = 1'b1;
    #1;
    check_eq("tx_async_rst", {31'h0, tx}, 32'h1);
    repeat (2) @(negedge pclk);
    prst = 1'b0;
    apb_read(32'd1, d, e);
    check_eq("post_rst_status", d, 32'h5);
    apb_read(32'd0, d, e);
    check_eq("post_rst_csr", d, 32'h0);
    check_eq("post_rst_irq", {31'h0, interupt_out}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/topp.md
Name: topp

Overview:
- APB-slave UART: 32-bit register interface, TX FIFO with serializer, RX deserializer with RX FIFO, one level interrupt output.
- Top-level UART peripheral on the APB bus.
- Frame format and baud rate are programmable through a control register (CSR).

Parameters:
- FIFO_DEPTH, 8, entries in each of the TX and RX byte FIFOs (power of 2, ≥2).
- CSR_RESET, 32'h0000_0000, reset value of the CSR.

Ports:
- pclk  in  1  system clock; all logic on its rising edge.
- prst  in  1  asynchronous, active-high reset.
- p_sel  in  1  APB select.
- p_en  in  1  APB enable (access phase).
- p_wr  in  1  1 = write, 0 = read.
- p_addr  in  32  word index; only values 0–3 are decoded.
- pw_data  in  32  write data.
- p_ready  out  1  transfer ready; tied to 1 (zero wait states).
- pr_data  out  32  read data.
- pslverr  out  1  transfer error, valid in the access cycle.
- tx  out  1  serial output; idles high.
- rx  in  1  serial input; passes through a 2-flop synchronizer.
- interupt_out  out  1  level interrupt.

Behaviour:
- Transfers: every pclk cycle with p_sel & p_en & p_ready = 1 is one transfer, so holding p_en high performs back-to-back transfers. pr_data and pslverr are combinational in that cycle. pr_data = 0 when not reading.
- Register map:
  - addr 0 CSR: read/write.
  - addr 1 STATUS: read-only.
  - addr 2 TXDATA: write-only; pushes pw_data[7:0].
  - addr 3 RXDATA: read-only; pops the RX FIFO, returns {24'b0, byte}.
- CSR fields:
  - [3:0] data bits; 5..8 legal, <5 treated as 5, >8 as 8.
  - [4] parity enable.
  - [5] 1 = odd parity, 0 = even.
  - [6] 1 = two stop bits.
  - [7] loopback (optional feature only).
  - [15:8] DIV; bit period = DIV+1 pclk cycles.
  - [16] RX-not-empty interrupt enable.
  - [17] error interrupt enable.
  - Other bits read 0.
- STATUS bits: [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [4] parity_err, [5] frame_err, [6] overrun, [7] tx_busy. Bits [6:4] are sticky and cleared by a STATUS read.
- pslverr = 1, with no side effect, when:
  - address > 3;
  - write to addr 1 or 3;
  - read of addr 2;
  - TXDATA write while TX FIFO full;
  - RXDATA read while RX FIFO empty (pr_data = 0).
- Reset values: CSR = CSR_RESET, FIFOs empty, sticky flags 0, tx = 1, pslverr = 0, interupt_out = 0, p_ready = 1.
- TX FSM: IDLE → START → DATA → PARITY (if enabled) → STOP (1 or 2) → IDLE.
  - Leaves IDLE the cycle after the TX FIFO is non-empty; pops the byte on entering START.
  - Each state lasts DIV+1 cycles. Data goes LSB first.
  - CSR is sampled at START; a mid-frame CSR write affects only the next frame.
  - Back-to-back frames have no idle gap.
- RX FSM: IDLE → START → DATA → PARITY → STOP → IDLE.
  - Falling edge on the synchronized rx starts a frame; the bit is checked at (DIV+1)/2 cycles and, if still low, counting continues. A high line there is a false start: return to IDLE.
  - Each bit is sampled at its midpoint.
  - Only the first stop bit is checked; stop = 0 sets frame_err.
  - Parity mismatch sets parity_err.
  - The received byte is pushed even when an error flag is set. If the RX FIFO is full, the byte is dropped and overrun is set.
- FIFOs: a push and a pop in the same cycle are both honoured. Pointers wrap modulo FIFO_DEPTH.
- interupt_out = (CSR[16] & ~rx_empty) | (CSR[17] & (parity_err | frame_err | overrun)); registered, so one cycle of latency.
- Reset mid-frame aborts both FSMs immediately: tx = 1 and the FIFO contents are lost.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined: when CSR[7] = 1, the receiver's input is internal tx instead of rx, and the tx pin is held at 1.
- Not defined: CSR[7] reads 0 and has no effect; the receiver always uses rx.

Test Plan:
- Reset → STATUS read = 0x0000_0005; tx = 1; interupt_out = 0; CSR read = 0.
- Write CSR 0x778 (8 data bits, odd parity, 2 stop, DIV = 7), then TXDATA 0x3a3a3a3a → tx: 8-cycle start 0, then data bits 0,1,0,1,1,1,0,0, parity 1, two stop 1 (96 cycles total).
- With rx tied to tx, write 0x3a then 0xf6, wait 1400 cycles → RXDATA reads 0x3a then 0xf6, no error flags. A further RXDATA read gives pslverr = 1, pr_data = 0.
- Inject a frame on rx with wrong parity, then one with stop = 0 → STATUS[4] = 1 and [5] = 1. A second STATUS read shows them cleared. With CSR[17] = 1, interupt_out = 1 until cleared.
- Write FIFO_DEPTH+2 TXDATA bytes back-to-back → the write after full gets pslverr = 1. Writes to addr 1, addr 3 and addr 5 → pslverr = 1.
- Assert prst mid-frame → tx = 1 asynchronously, both FIFOs empty, CSR = CSR_RESET.
